// File: rtl/clock_gate_ctrl.sv
// Enable controller for the core clock gate: idle hysteresis, sleep, and wake settle.
// Optional gated-cycle statistics counter is enabled with `define CG_CTRL_STATS_EN.
module clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sleep_req_i,
  input  logic        busy_i,
  input  logic        wake_i,
  output logic        cg_en_o,
  output logic        sleeping_o,
  output logic [31:0] gated_cycles_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WakeLast = 8'(WAKE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cg_en_q, cg_en_d;
  logic       sleeping_q, sleeping_d;
  logic       qualify;

  // wake_i is folded into the qualifying term, so wake beats sleep in RUN and DRAIN.
  assign qualify = sleep_req_i && !busy_i && !wake_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (qualify) begin
          if (IDLE_CYCLES == 1) begin
            state_d = SLEEP;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
            cnt_d   = 8'd1;
          end
        end
      end
      DRAIN: begin
        if (!qualify) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == IdleLast) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SLEEP: begin
        if (wake_i) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == WakeLast) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    cg_en_d    = (state_d != SLEEP);
    sleeping_d = (state_d == SLEEP) || (state_d == WAKE);
  end

  // Outputs are decoded from the next state so they register in the same update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      cg_en_q    <= 1'b1;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cg_en_q    <= cg_en_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign cg_en_o    = cg_en_q;
  assign sleeping_o = sleeping_q;

`ifdef CG_CTRL_STATS_EN
  logic [31:0] gated_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gated_q <= '0;
    end else if (!cg_en_q && (gated_q != '1)) begin
      gated_q <= gated_q + 32'd1;
    end
  end

  assign gated_cycles_o = gated_q;
`else
  assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed self-checking bench for clock_gate_ctrl (IDLE=4/WAKE=2 plus an IDLE=1/WAKE=1 instance).
// Cycle k is the period ending at the k-th rising edge after reset release; outputs checked mid-cycle.
module tb_clock_gate_ctrl;

  logic        clk;
  logic        rst;
  logic        sr;
  logic        busy;
  logic        wake;
  logic        cg_en;
  logic        sleeping;
  logic [31:0] gated;
  logic        cg_en1;
  logic        sleeping1;
  logic [31:0] gated1;

  int vectors;
  int miscompares;

  clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sleep_req_i    (sr),
    .busy_i         (busy),
    .wake_i         (wake),
    .cg_en_o        (cg_en),
    .sleeping_o     (sleeping),
    .gated_cycles_o (gated)
  );

  clock_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut1 (
    .clk_i          (clk),
    .rst_i          (rst),
    .sleep_req_i    (sr),
    .busy_i         (busy),
    .wake_i         (wake),
    .cg_en_o        (cg_en1),
    .sleeping_o     (sleeping1),
    .gated_cycles_o (gated1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sr = 1'b0; busy = 1'b0; wake = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (cg_en !== 1'b1) begin
      miscompares++; $display("FAIL reset_cg_en: got %b expected 1", cg_en);
    end
    vectors++;
    if (sleeping !== 1'b0) begin
      miscompares++; $display("FAIL reset_sleeping: got %b expected 0", sleeping);
    end
    vectors++;
    if (gated !== 32'd0) begin
      miscompares++; $display("FAIL reset_gated: got %h expected 0", gated);
    end
    vectors++;
    if (cg_en1 !== 1'b1 || sleeping1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_dut1: got cg_en=%b sleeping=%b expected 1/0", cg_en1, sleeping1);
    end
  endtask

  // Qualifying from cycle 0: gate drops at cycle 4 (cycle 1 for the IDLE=1 instance).
  task automatic test_basic();
    logic exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      exp = (c < 4);
      vectors++;
      if (cg_en !== exp) begin
        miscompares++; $display("FAIL basic_cg_en c=%0d: got %b expected %b", c, cg_en, exp);
      end
      vectors++;
      if (sleeping !== !exp) begin
        miscompares++; $display("FAIL basic_sleeping c=%0d: got %b expected %b", c, sleeping, !exp);
      end
      exp = (c < 1);
      vectors++;
      if (cg_en1 !== exp) begin
        miscompares++; $display("FAIL basic_idle1_cg_en c=%0d: got %b expected %b", c, cg_en1, exp);
      end
      sr = 1'b1; busy = 1'b0; wake = 1'b0;
    end
  endtask

  // Continues from test_basic: wake pulse at cycle 10.
  task automatic test_wake();
    logic exp_en;
    logic exp_sl;
    for (int c = 10; c < 15; c++) begin
      @(negedge clk);
      exp_en = (c != 10);
      exp_sl = (c <= 12);
      vectors++;
      if (cg_en !== exp_en) begin
        miscompares++; $display("FAIL wake_cg_en c=%0d: got %b expected %b", c, cg_en, exp_en);
      end
      vectors++;
      if (sleeping !== exp_sl) begin
        miscompares++; $display("FAIL wake_sleeping c=%0d: got %b expected %b", c, sleeping, exp_sl);
      end
      exp_en = (c != 10);
      exp_sl = (c <= 11);
      vectors++;
      if (cg_en1 !== exp_en || sleeping1 !== exp_sl) begin
        miscompares++;
        $display("FAIL wake_idle1 c=%0d: got cg_en=%b sleeping=%b expected %b/%b", c, cg_en1, sleeping1, exp_en, exp_sl);
      end
`ifndef CG_CTRL_STATS_EN
      vectors++;
      if (gated !== 32'd0) begin
        miscompares++; $display("FAIL wake_gated_tied c=%0d: got %h expected 0", c, gated);
      end
`endif
      sr = 1'b0; busy = 1'b0; wake = (c == 10);
    end
  endtask

  // busy in cycle 2 restarts hysteresis: qualifying 3..6, gate drops at 7.
  task automatic test_busy_abort();
    logic exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      exp = (c < 7);
      vectors++;
      if (cg_en !== exp) begin
        miscompares++; $display("FAIL busy_cg_en c=%0d: got %b expected %b", c, cg_en, exp);
      end
      vectors++;
      if (sleeping !== !exp) begin
        miscompares++; $display("FAIL busy_sleeping c=%0d: got %b expected %b", c, sleeping, !exp);
      end
      sr = 1'b1; busy = (c == 2); wake = 1'b0;
    end
  endtask

  // wake at 1 and sleep_req low at 5 each restart DRAIN; gate at 10; SLEEP ignores busy/sleep_req.
  task automatic test_drain_abort();
    logic exp;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      exp = (c < 10);
      vectors++;
      if (cg_en !== exp) begin
        miscompares++; $display("FAIL drain_cg_en c=%0d: got %b expected %b", c, cg_en, exp);
      end
      vectors++;
      if (sleeping !== !exp) begin
        miscompares++; $display("FAIL drain_sleeping c=%0d: got %b expected %b", c, sleeping, !exp);
      end
      sr   = !(c == 5 || c >= 10);
      busy = (c >= 10);
      wake = (c == 1);
    end
  endtask

  task automatic test_reset_in_sleep();
    @(negedge clk);
    vectors++;
    if (cg_en !== 1'b0) begin
      miscompares++; $display("FAIL rst_sleep_pre: got %b expected 0", cg_en);
    end
    rst = 1'b1; sr = 1'b1; busy = 1'b0; wake = 1'b0;
    @(negedge clk);
    rst = 1'b0; sr = 1'b0;
    vectors++;
    if (cg_en !== 1'b1 || sleeping !== 1'b0) begin
      miscompares++; $display("FAIL rst_sleep: got cg_en=%b sleeping=%b expected 1/0", cg_en, sleeping);
    end
    vectors++;
    if (gated !== 32'd0) begin
      miscompares++; $display("FAIL rst_sleep_gated: got %h expected 0", gated);
    end
    vectors++;
    if (cg_en1 !== 1'b1 || sleeping1 !== 1'b0) begin
      miscompares++; $display("FAIL rst_sleep_idle1: got cg_en=%b sleeping=%b expected 1/0", cg_en1, sleeping1);
    end
  endtask

  // sleep_req+wake for 20 cycles never leaves RUN, so dropping wake needs the full 4-cycle hysteresis.
  task automatic test_simultaneous();
    logic exp;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      exp = (c < 24);
      vectors++;
      if (cg_en !== exp) begin
        miscompares++; $display("FAIL simul_cg_en c=%0d: got %b expected %b", c, cg_en, exp);
      end
      vectors++;
      if (sleeping !== !exp) begin
        miscompares++; $display("FAIL simul_sleeping c=%0d: got %b expected %b", c, sleeping, !exp);
      end
      sr = 1'b1; busy = 1'b0; wake = (c < 20);
    end
  endtask

`ifdef CG_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c < 23; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 11 || c == 17) begin
        vectors++;
        if (gated !== 32'd7) begin
          miscompares++; $display("FAIL stats_count c=%0d: got %0d expected 7", c, gated);
        end
      end
      if (c == 11) begin
        vectors++;
        if (gated1 !== 32'd10) begin
          miscompares++; $display("FAIL stats_idle1 c=11: got %0d expected 10", gated1);
        end
      end
      if (c == 17) begin
        vectors++;
        if (cg_en !== 1'b0) begin
          miscompares++; $display("FAIL stats_regate c=17: got %b expected 0", cg_en);
        end
        force dut.gated_q = 32'hFFFF_FFFE;
        #1;
        release dut.gated_q;
      end
      if (c == 18 || c == 22) begin
        vectors++;
        if (gated !== 32'hFFFF_FFFF) begin
          miscompares++; $display("FAIL stats_saturate c=%0d: got %h expected ffffffff", c, gated);
        end
      end
      sr = !(c >= 10 && c <= 12); busy = 1'b0; wake = (c == 10);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; sr = 1'b0; busy = 1'b0; wake = 1'b0;
    test_reset();
    test_basic();
    test_wake();
    test_busy_abort();
    test_drain_abort();
    test_reset_in_sleep();
    test_simultaneous();
`ifdef CG_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Enable controller for the core clock gate. It runs on the free-running clock and decides when the core clock may be stopped. The core requests sleep (WFI) and the bus reports outstanding traffic. After a programmable idle hysteresis, the block drops the gate enable. When a wake source fires, it re-enables the clock and holds the core in a "waking" state for a fixed settle period. Its `cg_en_o` drives the `en_i` input of the clock-gate cell sitting in front of the core.

## Interface
Parameters:
- `IDLE_CYCLES`, default 4: number of consecutive qualifying cycles before the clock is gated. Legal range 1..255.
- `WAKE_CYCLES`, default 2: number of cycles the clock runs with `sleeping_o` still high after a wake. Legal range 1..255.

Ports:
- `clk_i` in 1: free-running (ungated) clock. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `sleep_req_i` in 1: core requests sleep (level).
- `busy_i` in 1: bus/LSU has an outstanding transaction; blocks gating.
- `wake_i` in 1: OR of pending interrupt and debug request (level).
- `cg_en_o` out 1: clock-gate enable. Driven directly from a flop; never combinational.
- `sleeping_o` out 1: high while in SLEEP or WAKE.
- `gated_cycles_o` out 32: count of gated cycles (see Configuration).

## Operation
- A cycle is **qualifying** when `sleep_req_i && !busy_i && !wake_i`.
- FSM states: RUN, DRAIN, SLEEP, WAKE. There is one 8-bit counter `cnt`.
- **RUN**: `cg_en_o`=1, `sleeping_o`=0.
  - Qualifying cycle with IDLE_CYCLES==1 → SLEEP.
  - Qualifying cycle otherwise → DRAIN, `cnt`=1.
  - Non-qualifying cycle → stay in RUN.
- **DRAIN**: `cg_en_o`=1.
  - Non-qualifying cycle (any of: `sleep_req_i` low, `busy_i` high, `wake_i` high) → RUN, `cnt`=0.
  - Qualifying cycle with `cnt`==IDLE_CYCLES-1 → SLEEP.
  - Qualifying cycle otherwise → `cnt`+1.
- **SLEEP**: `cg_en_o`=0, `sleeping_o`=1. `sleep_req_i` and `busy_i` are ignored.
  - `wake_i` high → WAKE, `cnt`=0. `cg_en_o` rises in the same registered update.
- **WAKE**: `cg_en_o`=1, `sleeping_o`=1. `wake_i` is ignored.
  - `cnt`==WAKE_CYCLES-1 → RUN.
  - Otherwise → `cnt`+1.
- Priority rules:
  - `wake_i` beats `sleep_req_i` in every state.
  - `rst_i` beats everything.
- `cg_en_o` and `sleeping_o` are registered alongside the state, so the gate sees a clean enable level for the whole low phase.

## Timing
- Reset values: state=RUN, `cg_en_o`=1, `sleeping_o`=0, `cnt`=0, `gated_cycles_o`=0.
- Reset asserted in any state (including SLEEP) → `cg_en_o`=1 on the cycle after the reset edge.
- Gating latency: if cycles 0..IDLE_CYCLES-1 all qualify, `cg_en_o` is low from cycle IDLE_CYCLES onward.
- Wake latency: `wake_i` high in SLEEP at cycle t → `cg_en_o`=1 at t+1, `sleeping_o` falls at t+1+WAKE_CYCLES.
- A single non-qualifying cycle inside DRAIN restarts the full hysteresis.
- `wake_i` and `sleep_req_i` asserted in the same cycle from RUN → the block stays in RUN.
- Counter width: 8 bits, with no wrap inside DRAIN or WAKE because the parameters are at most 255.

## Configuration
- **`CG_CTRL_STATS_EN` defined**:
  - `gated_cycles_o` increments by 1 on every clock edge where `cg_en_o` is 0 at that edge.
  - It saturates at 32'hFFFF_FFFF and never wraps.
  - It is cleared only by `rst_i`.
- **`CG_CTRL_STATS_EN` undefined**:
  - The counter logic is removed and `gated_cycles_o` is tied to 0.
  - The port still exists, and FSM behaviour is identical.

## Test plan
All scenarios use IDLE_CYCLES=4 and WAKE_CYCLES=2.
- **Basic gating**: hold `sleep_req_i`=1, `busy_i`=0 from cycle 0 → `cg_en_o`=1 in cycles 0..3 and 0 from cycle 4. `sleeping_o`=1 from cycle 4.
- **Busy abort**: same as above, with `busy_i`=1 in cycle 2 only → `cg_en_o` stays 1. The gate first drops at cycle 7 (qualifying cycles 3..6).
- **Wake and settle**: in SLEEP, pulse `wake_i` at cycle 10 → `cg_en_o`=1 at 11, `sleeping_o`=1 at 11..12 and 0 at 13. State is RUN at 13.
- **Simultaneous request and wake**: `sleep_req_i`=1 and `wake_i`=1 held for 20 cycles → `cg_en_o` never drops, and the FSM never leaves RUN.
- **Reset in SLEEP**: assert `rst_i` for 1 cycle while gated → `cg_en_o`=1, `sleeping_o`=0 and `gated_cycles_o`=0 on the next cycle.
- **Statistics** (with `CG_CTRL_STATS_EN`): after gating at cycle 4 and waking at cycle 10 → `gated_cycles_o`=7 at cycle 11. Then force the counter to 32'hFFFF_FFFE, gate for 5 more cycles, and check it reads 32'hFFFF_FFFF.
